// File: rtl/bram1_client.sv
// Requester for a single-ported BRAM: issues read/write requests, tracks read latency
// and returns read data in order through a credit-protected response FIFO.
module bram1_client #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter int PIPELINED  = 0,
    parameter int RESP_DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do
);

    localparam int LAT = (PIPELINED != 0) ? 2 : 1;
    localparam int CW  = $clog2(RESP_DEPTH + 1);
    localparam int PW  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(RESP_DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(RESP_DEPTH - 1);

    logic [LAT-1:0]        tag;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         credits;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
    logic                  accept;
    logic                  rd_accept;
    logic                  push;
    logic                  pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    // Every outstanding read owns a FIFO slot, so a push can never find the FIFO full.
    assign credits    = DEPTH_C - fifo_count - inflight;
    assign req_ready  = !RST && (req_write || (credits != '0));
    assign accept     = req_valid && req_ready;
    assign rd_accept  = accept && !req_write;
    assign push       = tag[LAT-1];
    assign resp_valid = !RST && (fifo_count != '0);
    assign pop        = resp_valid && resp_ready;
    assign resp_data  = fifo_mem[head];

    assign bram_en    = accept;
    assign bram_we    = accept && req_write;
    assign bram_addr  = req_addr;
    assign bram_di    = req_data;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tag        <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            head       <= '0;
            tail       <= '0;
        end else begin
            tag <= LAT'({tag, rd_accept});

            case ({rd_accept, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and count decide which entries are meaningful.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[tail] <= bram_do;
    end

endmodule

// File: tb/tb_bram1_client.sv
// Directed bench for bram1_client: latency-1/depth-2 instance (A) and latency-2/depth-3 instance (B),
// each attached to a zero-initialised BRAM model.
module tb_bram1_client;

    logic       CLK = 1'b0;
    logic       RST;
    always #5 CLK = ~CLK;

    logic       a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ready;
    logic [7:0] a_req_addr, a_req_data, a_resp_data;
    logic       a_bram_en, a_bram_we;
    logic [7:0] a_bram_addr, a_bram_di, a_bram_do;

    logic       b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready;
    logic [7:0] b_req_addr, b_req_data, b_resp_data;
    logic       b_bram_en, b_bram_we;
    logic [7:0] b_bram_addr, b_bram_di, b_bram_do;

    bram1_client #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .PIPELINED(0), .RESP_DEPTH(2)) dut_a (
        .CLK(CLK), .RST(RST),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_data(a_req_data),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_data(a_resp_data),
        .bram_en(a_bram_en), .bram_we(a_bram_we), .bram_addr(a_bram_addr),
        .bram_di(a_bram_di), .bram_do(a_bram_do)
    );

    bram1_client #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .PIPELINED(1), .RESP_DEPTH(3)) dut_b (
        .CLK(CLK), .RST(RST),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_data(b_req_data),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data),
        .bram_en(b_bram_en), .bram_we(b_bram_we), .bram_addr(b_bram_addr),
        .bram_di(b_bram_di), .bram_do(b_bram_do)
    );

    // BRAM models: A has one output register, B an extra pipeline register.
    logic [7:0] a_mem [256];
    logic [7:0] b_mem [256];
    logic [7:0] b_stage;

    always @(posedge CLK) begin
        if (a_bram_en) begin
            if (a_bram_we) begin
                a_mem[a_bram_addr] <= a_bram_di;
                a_bram_do          <= a_bram_di;
            end else begin
                a_bram_do <= a_mem[a_bram_addr];
            end
        end
    end

    always @(posedge CLK) begin
        if (b_bram_en) begin
            if (b_bram_we) begin
                b_mem[b_bram_addr] <= b_bram_di;
                b_stage            <= b_bram_di;
            end else begin
                b_stage <= b_mem[b_bram_addr];
            end
        end
        b_bram_do <= b_stage;
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] shadow_a [8];
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_a(input logic [7:0] addr, input logic [7:0] data);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = addr; a_req_data = data;
        #1;
        check("wr_a_en", {a_req_ready, a_bram_en, a_bram_we}, 3'b111);
        shadow_a[addr[2:0]] = data;
        tick();
        a_req_valid = 1'b0;
    endtask

    task automatic write_b(input logic [7:0] addr, input logic [7:0] data);
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = addr; b_req_data = data;
        #1;
        check("wr_b_en", {b_req_ready, b_bram_en, b_bram_we}, 3'b111);
        tick();
        b_req_valid = 1'b0;
    endtask

    int   issued;
    int   got;
    int   accepted;
    logic acc;
    logic exp_ready;
    logic [7:0] exp_data;

    initial begin
        for (int i = 0; i < 256; i++) begin
            a_mem[i] = 8'h00;
            b_mem[i] = 8'h00;
        end
        for (int i = 0; i < 8; i++) shadow_a[i] = 8'h00;
        a_bram_do = 8'h00; b_bram_do = 8'h00; b_stage = 8'h00;
        RST = 1'b1;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_data = '0; a_resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_data = '0; b_resp_ready = 1'b0;

        // T1: reset holds everything quiet, then write/read back
        for (int i = 0; i < 3; i++) begin
            a_req_valid = 1'b1;
            #1;
            check("rst_ready", a_req_ready, 1'b0);
            check("rst_resp_valid", a_resp_valid, 1'b0);
            check("rst_bram_en", a_bram_en, 1'b0);
            tick();
        end
        RST = 1'b0; a_req_valid = 1'b0;
        #1;
        check("post_rst_ready_a", a_req_ready, 1'b1);
        check("post_rst_ready_b", b_req_ready, 1'b1);
        check("post_rst_resp_valid", a_resp_valid, 1'b0);

        write_a(8'd3, 8'hA5);
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'd3;
        #1;
        check("t1_rd_issue", {a_req_ready, a_bram_en, a_bram_we, a_bram_addr}, {3'b110, 8'd3});
        tick();
        a_req_valid = 1'b0; a_resp_ready = 1'b1;
        #1;
        check("t1_not_yet", a_resp_valid, 1'b0);
        tick();
        check("t1_valid", a_resp_valid, 1'b1);
        check("t1_data", a_resp_data, 8'hA5);
        tick();
        check("t1_empty", a_resp_valid, 1'b0);

        // T2: fill 0..7, then stream reads with resp_ready held high
        for (int i = 0; i < 8; i++) write_a(8'(i), 8'(8'h10 + i));
        issued = 0; got = 0;
        for (int c = 0; c < 30; c++) begin
            a_req_valid = (issued < 8); a_req_write = 1'b0; a_req_addr = 8'(issued);
            #1;
            if (c < 2) check("t2_ready_early", a_req_ready, 1'b1);
            if (a_resp_valid) begin
                check("t2_data", a_resp_data, 8'(8'h10 + got));
                got++;
            end
            acc = a_req_valid && a_req_ready;
            tick();
            if (acc) issued++;
        end
        a_req_valid = 1'b0;
        check("t2_issued", issued, 8);
        check("t2_responses", got, 8);

        // T3: no consumer -> credits run out for reads but writes still go through
        a_resp_ready = 1'b0; accepted = 0;
        for (int c = 0; c < 5; c++) begin
            a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'(accepted);
            #1;
            acc = a_req_valid && a_req_ready;
            tick();
            if (acc) accepted++;
        end
        check("t3_accepted", accepted, 2);
        #1;
        check("t3_rd_blocked", a_req_ready, 1'b0);
        check("t3_head_held", a_resp_data, 8'h10);
        a_req_write = 1'b1; a_req_addr = 8'd7; a_req_data = 8'h17;
        #1;
        check("t3_wr_ok", {a_req_ready, a_bram_we}, 2'b11);
        shadow_a[7] = 8'h17;
        tick();
        a_req_valid = 1'b0; a_req_write = 1'b0; a_resp_ready = 1'b1;
        #1;
        check("t3_drain0", {a_resp_valid, a_resp_data}, {1'b1, 8'h10});
        tick();
        check("t3_drain1", {a_resp_valid, a_resp_data}, {1'b1, 8'h11});
        tick();
        check("t3_drained", a_resp_valid, 1'b0);
        check("t3_ready_back", a_req_ready, 1'b1);

        // T4: reset with reads outstanding discards them
        a_resp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'(2 + i);
            #1;
            check("t4_rd_acc", a_req_ready, 1'b1);
            tick();
        end
        a_req_valid = 1'b0; RST = 1'b1;
        #1;
        check("t4_rst_ready", a_req_ready, 1'b0);
        check("t4_rst_valid", a_resp_valid, 1'b0);
        tick();
        RST = 1'b0; a_resp_ready = 1'b1;
        #1;
        check("t4_ready_after", a_req_ready, 1'b1);
        for (int c = 0; c < 6; c++) begin
            #1;
            check("t4_no_resp", a_resp_valid, 1'b0);
            tick();
        end

        // T5: latency-2 instance
        for (int i = 0; i < 6; i++) write_b(8'(i), 8'(8'h60 + i));
        write_b(8'd9, 8'h5C);
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 8'd9;
        #1;
        check("t5_rd_acc", {b_req_ready, b_bram_en}, 2'b11);
        tick();
        b_req_valid = 1'b0; b_resp_ready = 1'b1;
        #1;
        check("t5_n1", b_resp_valid, 1'b0);
        tick();
        check("t5_n2", b_resp_valid, 1'b0);
        tick();
        check("t5_valid", {b_resp_valid, b_resp_data}, {1'b1, 8'h5C});
        tick();
        check("t5_empty", b_resp_valid, 1'b0);
        issued = 0; got = 0;
        for (int c = 0; c < 30; c++) begin
            b_req_valid = (issued < 6); b_req_write = 1'b0; b_req_addr = 8'(issued);
            #1;
            if (c < 3) check("t5_ready_early", b_req_ready, 1'b1);
            if (b_resp_valid) begin
                check("t5_data", b_resp_data, 8'(8'h60 + got));
                got++;
            end
            acc = b_req_valid && b_req_ready;
            tick();
            if (acc) issued++;
        end
        b_req_valid = 1'b0;
        check("t5_issued", issued, 6);
        check("t5_responses", got, 6);

        // T6: random traffic on A against an in-order scoreboard
        exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            a_req_valid  = ($urandom_range(0, 1) == 1);
            a_req_write  = ($urandom_range(0, 2) == 0);
            a_req_addr   = 8'($urandom_range(0, 7));
            a_req_data   = 8'($urandom);
            a_resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = a_req_write || (exp_q.size() < 2);
            check("t6_ready", a_req_ready, exp_ready);
            if (a_resp_valid && a_resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("t6_extra_resp", 1'b1, 1'b0);
                end else begin
                    exp_data = exp_q.pop_front();
                    check("t6_data", a_resp_data, exp_data);
                end
            end
            if (a_req_valid && a_req_ready) begin
                if (a_req_write) shadow_a[a_req_addr[2:0]] = a_req_data;
                else             exp_q.push_back(shadow_a[a_req_addr[2:0]]);
            end
            tick();
        end
        a_req_valid = 1'b0; a_resp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (a_resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("t6_extra_resp", 1'b1, 1'b0);
                end else begin
                    exp_data = exp_q.pop_front();
                    check("t6_drain_data", a_resp_data, exp_data);
                end
            end
            tick();
        end
        check("t6_all_returned", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
